ps2_host_tx: RTL and testbench

Host-to-device transmitter for the PS/2 port on the mini-games board. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard using the PS/2 host request protocol: clock inhibit, start request, device-clocked data, odd parity, stop and device ACK. It drives PS2_CLK/PS2_DAT through open-drain enables at the top level. It is the transmit counterpart of the keyboard scan-code receiver, and tells that receiver to ignore the bus while a transmit is in progress.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, transfer status codes, frame helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StRelease,
    StShift,
    StAck,
    StWaitIdle,
    StFail
  } ps2_state_e;

  typedef enum logic [1:0] {
    TxOk           = 2'd0,
    TxNoAck        = 2'd1,
    TxStartTimeout = 2'd2,
    TxXferTimeout  = 2'd3
  } ps2_tx_status_e;

  // Frame index of the stop bit; indices 0..8 are d0..d7 and parity.
  localparam logic [3:0] StopIdx = 4'd9;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pad input conditioning: 2-FF synchronizer, stability filter, registered falling-edge pulse.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CntW = $clog2(FILTER_LEN) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_fall;
  logic            w_settle;

  // The synchronized value has differed from the filtered one for FILTER_LEN cycles.
  assign w_settle = (r_sync[1] != r_level) && (r_cnt == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_fall <= w_settle & ~r_sync[1];
      if ((r_sync[1] == r_level) || w_settle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_settle) begin
        r_level <= r_sync[1];
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC  = 6000,
  parameter int unsigned START_TO_CYC = 750000,
  parameter int unsigned XFER_TO_CYC  = 100000,
  parameter int unsigned FILTER_LEN   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [1:0] tx_status,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned InhW   = $clog2(INHIBIT_CYC) + 1;
  localparam int unsigned StartW = $clog2(START_TO_CYC) + 1;
  localparam int unsigned XferW  = $clog2(XFER_TO_CYC) + 1;
  localparam logic [InhW-1:0]   InhLast   = InhW'(INHIBIT_CYC - 1);
  localparam logic [StartW-1:0] StartLast = StartW'(START_TO_CYC - 1);
  localparam logic [XferW-1:0]  XferLast  = XferW'(XFER_TO_CYC - 1);

  ps2_state_e     r_state, w_state_d;
  ps2_tx_status_e r_status, w_status_d;
  logic [8:0]        r_frame, w_frame_d;
  logic [3:0]        r_idx, w_idx_d;
  logic              r_dat_oe, w_dat_oe_d;
  logic              r_clk_oe, r_done, w_done_d, r_ready, r_rx_inh;
  logic [InhW-1:0]   r_inh_cnt;
  logic [StartW-1:0] r_start_cnt;
  logic [XferW-1:0]  r_xfer_cnt;
  logic              w_clk_level, w_clk_fall, w_dat_level, w_unused_dat_fall;
  logic              w_xfer_state, w_xfer_to;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (ps2_clk_i),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (ps2_dat_i),
    .o_level (w_dat_level),
    .o_fall  (w_unused_dat_fall)
  );

  // Transfer timeout spans SHIFT, ACK and WAIT_IDLE; it starts on entry to SHIFT.
  assign w_xfer_state = (r_state == StShift) || (r_state == StAck) || (r_state == StWaitIdle);
  assign w_xfer_to    = w_xfer_state && (r_xfer_cnt == XferLast);

  always_comb begin
    w_state_d  = r_state;
    w_status_d = r_status;
    w_frame_d  = r_frame;
    w_idx_d    = r_idx;
    w_dat_oe_d = r_dat_oe;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (tx_valid) begin
          w_frame_d = {odd_parity(tx_data), tx_data};
          w_state_d = StInhibit;
        end
      end
      StInhibit: begin
        if (r_inh_cnt == InhLast) begin
          w_dat_oe_d = 1'b1;
          w_state_d  = StReq;
        end
      end
      StReq: w_state_d = StRelease;
      StRelease: begin
        if (w_clk_fall) begin
          w_dat_oe_d = ~r_frame[0];
          w_idx_d    = 4'd1;
          w_state_d  = StShift;
        end else if (r_start_cnt == StartLast) begin
          w_status_d = TxStartTimeout;
          w_dat_oe_d = 1'b0;
          w_done_d   = 1'b1;
          w_state_d  = StFail;
        end
      end
      StShift, StAck, StWaitIdle: begin
        if (w_xfer_to) begin
          w_status_d = TxXferTimeout;
          w_dat_oe_d = 1'b0;
          w_done_d   = 1'b1;
          w_state_d  = StFail;
        end else if (r_state == StShift) begin
          if (w_clk_fall) begin
            if (r_idx == StopIdx) begin
              w_dat_oe_d = 1'b0;
              w_state_d  = StAck;
            end else begin
              w_dat_oe_d = ~r_frame[r_idx];
              w_idx_d    = r_idx + 4'd1;
            end
          end
        end else if (r_state == StAck) begin
          if (w_clk_fall) begin
            w_status_d = w_dat_level ? TxNoAck : TxOk;
            w_state_d  = StWaitIdle;
          end
        end else if (w_clk_level && w_dat_level) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      StFail:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_status    <= TxOk;
      r_frame     <= '0;
      r_idx       <= '0;
      r_dat_oe    <= 1'b0;
      r_clk_oe    <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
      r_rx_inh    <= 1'b0;
      r_inh_cnt   <= '0;
      r_start_cnt <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_status    <= w_status_d;
      r_frame     <= w_frame_d;
      r_idx       <= w_idx_d;
      r_dat_oe    <= w_dat_oe_d;
      r_clk_oe    <= (w_state_d == StInhibit) || (w_state_d == StReq);
      r_done      <= w_done_d;
      r_ready     <= (w_state_d == StIdle);
      r_rx_inh    <= (w_state_d != StIdle);
      r_inh_cnt   <= ((r_state == StInhibit) && (w_state_d == StInhibit)) ?
                     r_inh_cnt + 1'b1 : '0;
      r_start_cnt <= ((r_state == StRelease) && (w_state_d == StRelease)) ?
                     r_start_cnt + 1'b1 : '0;
      r_xfer_cnt  <= (w_xfer_state && (w_state_d != StFail) && (w_state_d != StIdle)) ?
                     r_xfer_cnt + 1'b1 : '0;
    end
  end

  assign tx_ready   = r_ready;
  assign tx_done    = r_done;
  assign tx_status  = r_status;
  assign rx_inhibit = r_rx_inh;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard model on the wired-AND bus.
module tb_ps2_host_tx;

  localparam int unsigned InhCyc  = 20;
  localparam int unsigned StartTo = 500;
  localparam int unsigned XferTo  = 4000;
  localparam int unsigned FiltLen = 2;
  localparam int          Half    = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, rx_inhibit, ps2_clk_oe, ps2_dat_oe;
  logic [1:0] tx_status;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_pad, ps2_dat_pad;

  assign ps2_clk_pad = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_pad = ~ps2_dat_oe & dev_dat;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC  (InhCyc),
    .START_TO_CYC (StartTo),
    .XFER_TO_CYC  (XferTo),
    .FILTER_LEN   (FiltLen)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_status  (tx_status),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_i  (ps2_clk_pad),
    .ps2_dat_i  (ps2_dat_pad),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         rel_cyc = 0;
  logic [1:0] done_status = 2'd0;
  logic       prev_clk_oe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt    <= done_cnt + 1;
      done_status <= tx_status;
      done_cyc    <= cyc;
    end
    if (prev_clk_oe && !ps2_clk_oe) rel_cyc <= cyc;
    prev_clk_oe <= ps2_clk_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame as the device should sample it: d0..d7, odd parity, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  // Device clocks nclk falls; samples data at the end of each low half, ACKs before fall 11.
  task automatic dev_clocks(input int nclk, input bit ack, output logic [9:0] samp,
                            output int fall_cyc);
    samp = '0;
    fall_cyc = -1;
    for (int i = 0; i < nclk; i++) begin
      dev_clk = 1'b0;
      if (i == 0) fall_cyc = cyc;
      repeat (Half) @(negedge clk);
      if (i < 10) samp[i] = ps2_dat_pad;
      dev_clk = 1'b1;
      repeat (Half / 2) @(negedge clk);
      if (i == 9 && ack) dev_dat = 1'b0;
      if (i == 10) dev_dat = 1'b1;
      repeat (Half / 2) @(negedge clk);
    end
  endtask

  task automatic start_tx(input logic [7:0] data, input bit poke);
    int   n;
    logic prevd, lastd;
    @(negedge clk);
    check("ready_before_accept", tx_ready, 1);
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    check("accept_clk_oe", ps2_clk_oe, 1);
    check("accept_ready_low", tx_ready, 0);
    check("accept_rx_inhibit", rx_inhibit, 1);
    n = 1;
    lastd = ps2_dat_oe;
    prevd = 1'b0;
    while (ps2_clk_oe && n < 1000) begin
      @(negedge clk);
      if (ps2_clk_oe) begin
        n++;
        prevd = lastd;
        lastd = ps2_dat_oe;
      end
    end
    check("clk_low_cycles", n, InhCyc + 1);
    check("dat_oe_before_clk_release", {prevd, lastd}, 2'b01);
    check("release_dat_oe", ps2_dat_oe, 1);
    if (poke) begin
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("busy_poke_ignored", tx_ready, 0);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic do_xfer(input logic [7:0] data, input bit ack, input int nclk, input bit poke,
                         output logic [9:0] samp, output logic [1:0] status,
                         output int fall_cyc, output int done_at);
    int d0, k;
    d0 = done_cnt;
    start_tx(data, poke);
    dev_clocks(nclk, ack, samp, fall_cyc);
    k = 0;
    while (done_cnt == d0 && k < int'(StartTo + XferTo) + 1000) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    check("done_pulse_count", done_cnt - d0, 1);
    check("idle_ready", tx_ready, 1);
    check("idle_rx_inhibit", rx_inhibit, 0);
    check("idle_clk_oe", ps2_clk_oe, 0);
    check("idle_dat_oe", ps2_dat_oe, 0);
    status  = done_status;
    done_at = done_cyc;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         poke;
    logic [1:0] exp_status;
  } vec_t;

  vec_t       vecs[8];
  logic [9:0] samp;
  logic [1:0] status;
  int         fall_cyc, done_at, d0, k;

  initial begin
    vecs[0] = '{8'hED, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 2'd0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 2'd0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 2'd1};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 2'd0};
    for (int i = 5; i < 8; i++) begin
      vecs[i].data = 8'($urandom);
      vecs[i].ack  = 1'($urandom_range(0, 1));
      vecs[i].poke = 1'b0;
      vecs[i].exp_status = vecs[i].ack ? 2'd0 : 2'd1;
    end

    repeat (3) @(negedge clk);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_dat_oe", ps2_dat_oe, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_tx_done", tx_done, 0);
    check("reset_tx_status", tx_status, 0);
    check("reset_rx_inhibit", rx_inhibit, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_xfer(vecs[i].data, vecs[i].ack, 11, vecs[i].poke, samp, status, fall_cyc, done_at);
      check($sformatf("frame_%02h", vecs[i].data), samp, exp_frame(vecs[i].data));
      check($sformatf("status_%02h", vecs[i].data), status, vecs[i].exp_status);
    end

    // Device never clocks.
    do_xfer(8'h12, 1'b1, 0, 1'b0, samp, status, fall_cyc, done_at);
    check("start_timeout_status", status, 2);
    check("start_timeout_cycles", done_at - rel_cyc, StartTo);

    // Device stops after five falls.
    do_xfer(8'h34, 1'b1, 5, 1'b0, samp, status, fall_cyc, done_at);
    check("xfer_timeout_status", status, 3);
    check("xfer_timeout_cycles", done_at - fall_cyc, 2 + FiltLen + 1 + XferTo);

    // Asynchronous reset while shifting zeros: lines must release between clock edges.
    d0 = done_cnt;
    start_tx(8'h00, 1'b0);
    dev_clocks(4, 1'b1, samp, fall_cyc);
    check("pre_reset_dat_oe", ps2_dat_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_dat_oe", ps2_dat_oe, 0);
    check("async_reset_clk_oe", ps2_clk_oe, 0);
    check("async_reset_ready", tx_ready, 1);
    check("async_reset_rx_inhibit", rx_inhibit, 0);
    #1 rst_n = 1'b1;
    k = 0;
    repeat (50) begin
      @(negedge clk);
      k++;
    end
    check("no_done_after_reset", done_cnt - d0, 0);
    check("ready_after_reset", tx_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
